dac_gain_ramp_array: RTL
========================

Name: dac_gain_ramp_array

Overview:
- Parametrised per-channel output gain stage between the DUC outputs and the DAC sample buses of the receive core.
- Generalises the fixed three-channel, 8-sample, 8-bit-gain arrangement to NUM_CH channels of SPC samples.
- Adds glitch-free gain ramping, per-channel soft mute, round-and-saturate arithmetic, and sticky saturation flags.

Parameters:
- NUM_CH, 3, number of independent DAC channels.
- SPC, 8, samples per clock per channel.
- SW, 16, signed sample width.
- GW, 8, unsigned gain width.
- GAIN_FRAC, 6, fractional bits of gain; 2^GAIN_FRAC is unity (64).
- RAMP_STEP, 4, gain LSBs moved per ramp tick.
- RAMP_DIV, 16, clock cycles per ramp tick (>=1).

Ports:
- clock  in  1  sample clock; all logic is rising-edge.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  din qualifier.
- din  in  NUM_CH*SPC*SW  channel c, sample s at bits [(c*SPC+s)*SW +: SW]; sample 0 is oldest.
- gain_target  in  NUM_CH*GW  requested gain per channel; level input, may change at any time.
- mute  in  NUM_CH  1 forces that channel's effective target to 0.
- sat_clr  in  1  single-cycle pulse; clears all sat_flag bits.
- out_valid  out  1  in_valid delayed 3 cycles.
- dout  out  NUM_CH*SPC*SW  scaled samples, same packing as din.
- ramp_busy  out  NUM_CH  channel is in RAMP state.
- sat_flag  out  NUM_CH  sticky saturation indicator.
- cur_gain  out  NUM_CH*GW  gain currently being applied.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - dout=0, out_valid=0, ramp_busy=0, sat_flag=0, cur_gain=0.
  - FSM IDLE, tick counter=0, pipeline valid bits=0.
  - Every channel comes out of reset muted and soft-starts toward its target.
- Effective target: tgt[c] = mute[c] ? 0 : gain_target[c].
- Per-channel FSM, states IDLE and RAMP:
  - IDLE: counter held at 0. If cur_gain != tgt, go to RAMP on the next edge with counter=0.
  - RAMP: counter increments each cycle. When counter==RAMP_DIV-1, counter wraps to 0 and cur_gain moves toward tgt by RAMP_STEP, clamped to tgt (never overshoots).
    - If the new cur_gain equals tgt, go to IDLE on the same edge.
    - If tgt changes to equal cur_gain between ticks, go to IDLE on the next edge; cur_gain is unchanged.
    - Direction is re-evaluated at every tick, so a target change mid-ramp reverses or extends the ramp without leaving RAMP.
  - ramp_busy[c] = (state==RAMP), registered.
  - First step lands RAMP_DIV cycles after entering RAMP.
- Datapath, 3-stage pipeline, latency 3 cycles, throughput one vector per clock:
  - S1: register din, in_valid, and a cur_gain snapshot. One gain applies to all SPC samples of a vector.
  - S2: signed product p = sample * {1'b0,gain}, width SW+GW+1.
  - S3: r = (p + 2^(GAIN_FRAC-1)) >>> GAIN_FRAC (arithmetic shift; round half toward +inf). Saturate r to [-2^(SW-1), 2^(SW-1)-1] and register to dout.
- dout updates every cycle regardless of in_valid; out_valid marks valid vectors.
- Gain 0 gives exactly 0 output.
- sat_flag[c]: set when any sample of channel c saturates in S3 while its S3 valid is 1. Cleared by sat_clr. Set and clear in the same cycle: set wins.
- Reset mid-ramp: all state returns to reset values immediately; the ramp restarts from 0 after release.

Test Plan:
- Unity pass-through: gain_target=64 all channels, mute=0, wait for ramp_busy=0. Drive ramp samples -> dout equals din exactly, out_valid 3 cycles after in_valid, sat_flag=0.
- Soft start: release reset with gain_target=64, RAMP_STEP=4, RAMP_DIV=16 -> ramp_busy rises on cycle 1; cur_gain goes 4,8,…,64 every 16 cycles (16 steps); ramp_busy falls on the same edge cur_gain reaches 64.
- Rounding, gain=32 (0.5): sample 3 -> 2; -3 -> -1; 1 -> 1; -1 -> 0; 32767 -> 16384.
- Saturation, gain=128 (2.0): sample 20000 -> 32767; -20000 -> -32768; sat_flag set. Pulse sat_clr with no further saturation -> flag clears. sat_clr coincident with saturation -> flag stays 1.
- Mute reversal mid-ramp: ramping 0->200, assert mute at cur_gain=40 -> cur_gain decreases 36,32,…,0 and ramp_busy falls at 0. Other channels unaffected.
- Reset mid-ramp: assert resetn=0 asynchronously between clock edges -> dout, cur_gain, ramp_busy, out_valid all 0 immediately. After release the ramp restarts from 0.

Source files
------------

// File: rtl/dac_gain_ramp_array_if.sv
// Sample bus between the DUC outputs and the DAC gain stage.
// Carries the input vector with its qualifier and the scaled output vector.
`timescale 1ns/1ps
interface dac_gain_ramp_array_if #(
  parameter int NUM_CH = 3,
  parameter int SPC    = 8,
  parameter int SW     = 16
);
  logic                      in_valid;
  logic [NUM_CH*SPC*SW-1:0]  din;
  logic                      out_valid;
  logic [NUM_CH*SPC*SW-1:0]  dout;

  modport master (
    output in_valid, din,
    input  out_valid, dout
  );

  modport slave (
    input  in_valid, din,
    output out_valid, dout
  );
endinterface

// File: rtl/dac_gain_ramp_array.sv
// Per-channel DAC gain stage: ramped gain, soft mute,
// round-and-saturate scaling and sticky saturation flags.
`timescale 1ns/1ps
module dac_gain_ramp_array #(
  parameter int NUM_CH    = 3,
  parameter int SPC       = 8,
  parameter int SW        = 16,
  parameter int GW        = 8,
  parameter int GAIN_FRAC = 6,
  parameter int RAMP_STEP = 4,
  parameter int RAMP_DIV  = 16
) (
  input  logic                 clock,
  input  logic                 resetn,
  dac_gain_ramp_array_if.slave bus,
  input  logic [NUM_CH*GW-1:0] gain_target,
  input  logic [NUM_CH-1:0]    mute,
  input  logic                 sat_clr,
  output logic [NUM_CH-1:0]    ramp_busy,
  output logic [NUM_CH-1:0]    sat_flag,
  output logic [NUM_CH*GW-1:0] cur_gain
);
  localparam int NS = NUM_CH * SPC;
  localparam int DW = NS * SW;
  localparam int PW = SW + GW + 1;
  localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [CW-1:0] DIV_M1 = CW'(RAMP_DIV - 1);
  localparam logic [GW:0]   STEP   = (GW+1)'(RAMP_STEP);

  localparam logic signed [PW:0] RND  = (PW+1)'(2 ** (GAIN_FRAC - 1));
  localparam logic signed [PW:0] MAXV = (PW+1)'(2 ** (SW - 1) - 1);
  localparam logic signed [PW:0] MINV = -MAXV - 1;

  typedef enum logic {IDLE, RAMP} state_t;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t          st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   g_q, g_d, tgt;
    logic [GW:0]     diff_up, diff_dn;

    assign tgt = mute[c] ? '0 : gain_target[c*GW +: GW];

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        st_q  <= IDLE;
        cnt_q <= '0;
        g_q   <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        g_q   <= g_d;
      end
    end

    // Direction is chosen at every tick, so a target move reverses mid-ramp.
    always_comb begin
      st_d    = st_q;
      cnt_d   = '0;
      g_d     = g_q;
      diff_up = {1'b0, tgt} - {1'b0, g_q};
      diff_dn = {1'b0, g_q} - {1'b0, tgt};
      unique case (st_q)
        IDLE: begin
          if (g_q != tgt) st_d = RAMP;
        end
        RAMP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == DIV_M1) begin
            cnt_d = '0;
            if (tgt > g_q)
              g_d = (diff_up > STEP) ?
                GW'({1'b0, g_q} + STEP) : tgt;
            else if (tgt < g_q)
              g_d = (diff_dn > STEP) ?
                GW'({1'b0, g_q} - STEP) : tgt;
            if (g_d == tgt) st_d = IDLE;
          end else if (g_q == tgt) begin
            st_d  = IDLE;
            cnt_d = '0;
          end
        end
        default: ;
      endcase
    end

    assign ramp_busy[c]           = (st_q == RAMP);
    assign cur_gain[c*GW +: GW]   = g_q;
  end

  logic                   v1, v2;
  logic [DW-1:0]          d1;
  logic [NUM_CH*GW-1:0]   g1;
  logic signed [PW-1:0]   p2 [NS];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      d1 <= '0;
      g1 <= '0;
      for (int i = 0; i < NS; i++) p2[i] <= '0;
    end else begin
      v1 <= bus.in_valid;
      d1 <= bus.din;
      g1 <= cur_gain;
      v2 <= v1;
      for (int i = 0; i < NS; i++)
        p2[i] <= $signed(d1[i*SW +: SW]) *
                 $signed({1'b0, g1[(i/SPC)*GW +: GW]});
    end
  end

  logic signed [PW:0]  rsum [NS];
  logic signed [PW:0]  r    [NS];
  logic [SW-1:0]       q    [NS];
  logic [NS-1:0]       ov;
  logic [NUM_CH-1:0]   sat_set;

  // Round half toward +inf, then clamp to the signed sample range.
  always_comb begin
    ov = '0;
    for (int i = 0; i < NS; i++) begin
      rsum[i] = {p2[i][PW-1], p2[i]} + RND;
      r[i]    = rsum[i] >>> GAIN_FRAC;
      q[i]    = r[i][SW-1:0];
      if (r[i] > MAXV) begin
        q[i]  = MAXV[SW-1:0];
        ov[i] = 1'b1;
      end else if (r[i] < MINV) begin
        q[i]  = MINV[SW-1:0];
        ov[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sat_set = '0;
    for (int c = 0; c < NUM_CH; c++)
      sat_set[c] = v2 && (|ov[c*SPC +: SPC]);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus.out_valid <= 1'b0;
      bus.dout      <= '0;
      sat_flag      <= '0;
    end else begin
      bus.out_valid <= v2;
      for (int i = 0; i < NS; i++)
        bus.dout[i*SW +: SW] <= q[i];
      sat_flag <= (sat_flag & ~{NUM_CH{sat_clr}}) | sat_set;
    end
  end
endmodule
